and_result_checker: RTL and testbench

//  Downstream scoreboard for the 2-bit AND stage: consumes each (a, b, out) triple it emits,

---
 rtl/and_result_checker.sv | 175 +++++++++++++++++
 tb/tb_and_result_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/and_result_checker.sv
// and_result_checker: scoreboard for the AND stage. Accepts (a, b, out)
// triples while a run is active, recomputes a & b, counts accepted samples
// and mismatches, and captures the first failing triple. At the end of the
// run it reports pass or fail and holds the result until the next start.
module and_result_checker #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_start,
  input  logic [CNT_W-1:0] io_numSamples,
  input  logic             io_stopOnError,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  input  logic [WIDTH-1:0] io_in_out,
  output logic             io_busy,
  output logic             io_done,
  output logic             io_pass,
  output logic [CNT_W-1:0] io_sampleCount,
  output logic [CNT_W-1:0] io_errCount,
  output logic             io_firstErr_valid,
  output logic [WIDTH-1:0] io_firstErr_a,
  output logic [WIDTH-1:0] io_firstErr_b,
  output logic [WIDTH-1:0] io_firstErr_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  // Run configuration, latched only when a run starts.
  logic [CNT_W-1:0] target_reg;
  logic             stop_reg;

  // Run statistics and first-mismatch capture.
  logic [CNT_W-1:0] sample_count_reg;
  logic [CNT_W-1:0] err_count_reg;
  logic             first_err_valid_reg;
  logic [WIDTH-1:0] first_err_a_reg;
  logic [WIDTH-1:0] first_err_b_reg;
  logic [WIDTH-1:0] first_err_out_reg;

  // Per-bit disagreement between the observed result and the recomputed AND.
  logic [WIDTH-1:0] bit_diff;
  logic             mismatch;
  logic             accept;
  logic             start_run;
  logic [CNT_W-1:0] sample_inc;
  logic             err_at_max;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_bit_cmp
      assign bit_diff[gi] = io_in_out[gi] ^ (io_in_a[gi] & io_in_b[gi]);
    end
  endgenerate

  assign mismatch   = |bit_diff;
  assign accept     = io_in_valid && (state_reg == ST_RUN);
  // A start pulse during a run is ignored; it only takes effect from IDLE/DONE.
  assign start_run  = io_start && (state_reg != ST_RUN);
  assign sample_inc = sample_count_reg + 1'b1;
  assign err_at_max = &err_count_reg;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a zero-length run completes immediately.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (io_start) begin
          state_next = (io_numSamples == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept && ((sample_inc == target_reg) || (mismatch && stop_reg))) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the current state and the registered statistics.
  always_comb begin
    io_in_ready = 1'b0;
    io_busy     = 1'b0;
    io_done     = 1'b0;
    io_pass     = 1'b0;
    case (state_reg)
      ST_RUN: begin
        io_in_ready = 1'b1;
        io_busy     = 1'b1;
      end
      ST_DONE: begin
        io_done = 1'b1;
        io_pass = (err_count_reg == '0) && (sample_count_reg == target_reg);
      end
      default: begin
        io_in_ready = 1'b0;
      end
    endcase
  end

  // Run configuration latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      target_reg <= '0;
      stop_reg   <= 1'b0;
    end else if (start_run) begin
      target_reg <= io_numSamples;
      stop_reg   <= io_stopOnError;
    end
  end

  // Sample and error counters; the error count saturates rather than wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_count_reg <= '0;
      err_count_reg    <= '0;
    end else if (start_run) begin
      sample_count_reg <= '0;
      err_count_reg    <= '0;
    end else if (accept) begin
      sample_count_reg <= sample_inc;
      if (mismatch && !err_at_max) begin
        err_count_reg <= err_count_reg + 1'b1;
      end
    end
  end

  // First-mismatch capture; later mismatches leave the captured triple alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      first_err_valid_reg <= 1'b0;
      first_err_a_reg     <= '0;
      first_err_b_reg     <= '0;
      first_err_out_reg   <= '0;
    end else if (start_run) begin
      first_err_valid_reg <= 1'b0;
      first_err_a_reg     <= '0;
      first_err_b_reg     <= '0;
      first_err_out_reg   <= '0;
    end else if (accept && mismatch && !first_err_valid_reg) begin
      first_err_valid_reg <= 1'b1;
      first_err_a_reg     <= io_in_a;
      first_err_b_reg     <= io_in_b;
      first_err_out_reg   <= io_in_out;
    end
  end

  assign io_sampleCount    = sample_count_reg;
  assign io_errCount       = err_count_reg;
  assign io_firstErr_valid = first_err_valid_reg;
  assign io_firstErr_a     = first_err_a_reg;
  assign io_firstErr_b     = first_err_b_reg;
  assign io_firstErr_out   = first_err_out_reg;

endmodule

// File: tb/tb_and_result_checker.sv
// Testbench for and_result_checker: directed scenarios plus randomized runs,
// every cycle compared against a run-level reference model of the scoreboard.
module tb_and_result_checker;

  localparam int WIDTH = 2;
  localparam int CNT_W = 16;
  localparam int ERR_MAX = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             io_start;
  logic [CNT_W-1:0] io_numSamples;
  logic             io_stopOnError;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a;
  logic [WIDTH-1:0] io_in_b;
  logic [WIDTH-1:0] io_in_out;
  logic             io_busy;
  logic             io_done;
  logic             io_pass;
  logic [CNT_W-1:0] io_sampleCount;
  logic [CNT_W-1:0] io_errCount;
  logic             io_firstErr_valid;
  logic [WIDTH-1:0] io_firstErr_a;
  logic [WIDTH-1:0] io_firstErr_b;
  logic [WIDTH-1:0] io_firstErr_out;

  and_result_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clock             (clock),
    .reset             (reset),
    .io_start          (io_start),
    .io_numSamples     (io_numSamples),
    .io_stopOnError    (io_stopOnError),
    .io_in_valid       (io_in_valid),
    .io_in_ready       (io_in_ready),
    .io_in_a           (io_in_a),
    .io_in_b           (io_in_b),
    .io_in_out         (io_in_out),
    .io_busy           (io_busy),
    .io_done           (io_done),
    .io_pass           (io_pass),
    .io_sampleCount    (io_sampleCount),
    .io_errCount       (io_errCount),
    .io_firstErr_valid (io_firstErr_valid),
    .io_firstErr_a     (io_firstErr_a),
    .io_firstErr_b     (io_firstErr_b),
    .io_firstErr_out   (io_firstErr_out)
  );

  always #5 clock = ~clock;

  int compared = 0;
  int mismatched = 0;

  // Reference model: a run is either active, finished, or neither.
  bit m_running, m_finished, m_stop, m_fe_valid;
  int m_target, m_count, m_err, m_fe_a, m_fe_b, m_fe_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_running = 0; m_finished = 0; m_stop = 0; m_fe_valid = 0;
    m_target = 0; m_count = 0; m_err = 0; m_fe_a = 0; m_fe_b = 0; m_fe_out = 0;
  endtask

  task automatic model_update(input bit rst, input bit start, input int num, input bit stop,
                              input bit valid, input int a, input int b, input int o);
    bit bad;
    if (rst) begin
      model_clear();
    end else if (start && !m_running) begin
      model_clear();
      m_target = num;
      m_stop = stop;
      if (num == 0) m_finished = 1;
      else m_running = 1;
    end else if (m_running && valid) begin
      m_count++;
      bad = (o != (a & b));
      if (bad) begin
        if (m_err < ERR_MAX) m_err++;
        if (!m_fe_valid) begin
          m_fe_valid = 1; m_fe_a = a; m_fe_b = b; m_fe_out = o;
        end
      end
      if (m_count == m_target || (bad && m_stop)) begin
        m_running = 0;
        m_finished = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("ready", 32'(io_in_ready), 32'(m_running));
    check("busy", 32'(io_busy), 32'(m_running));
    check("done", 32'(io_done), 32'(m_finished));
    check("pass", 32'(io_pass), 32'(m_finished && m_err == 0 && m_count == m_target));
    check("sampleCount", 32'(io_sampleCount), 32'(m_count));
    check("errCount", 32'(io_errCount), 32'(m_err));
    check("firstErr_valid", 32'(io_firstErr_valid), 32'(m_fe_valid));
    check("firstErr_a", 32'(io_firstErr_a), 32'(m_fe_a));
    check("firstErr_b", 32'(io_firstErr_b), 32'(m_fe_b));
    check("firstErr_out", 32'(io_firstErr_out), 32'(m_fe_out));
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model, compare.
  task automatic step(input bit rst, input bit start, input int num, input bit stop,
                      input bit valid, input int a, input int b, input int o);
    reset = rst; io_start = start; io_numSamples = CNT_W'(num); io_stopOnError = stop;
    io_in_valid = valid; io_in_a = WIDTH'(a); io_in_b = WIDTH'(b); io_in_out = WIDTH'(o);
    @(posedge clock);
    #1;
    model_update(rst, start, num, stop, valid, a, b, o);
    $display("t=%0t rst=%b start=%b v=%b a=%0d b=%0d o=%0d | busy=%b done=%b pass=%b cnt=%0d err=%0d",
             $time, rst, start, valid, a, b, o, io_busy, io_done, io_pass, io_sampleCount, io_errCount);
    compare_all();
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int a, b, o, num;
    bit stp;
    model_clear();
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    check("reset_done", 32'(io_done), 32'd0);
    check("reset_ready", 32'(io_in_ready), 32'd0);
    idle_step();

    // 1: all 16 combos, correct results.
    step(0, 1, 16, 0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      a = i >> 2; b = i & 3;
      step(0, 0, 0, 0, 1, a, b, a & b);
      if (i == 14) check("t1_done_early", 32'(io_done), 32'd0);
    end
    check("t1_count", 32'(io_sampleCount), 32'd16);
    check("t1_err", 32'(io_errCount), 32'd0);
    check("t1_done", 32'(io_done), 32'd1);
    check("t1_pass", 32'(io_pass), 32'd1);
    idle_step();

    // 2: one mismatch, no stop.
    step(0, 1, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    step(0, 0, 0, 0, 1, 3, 1, 3);
    step(0, 0, 0, 0, 1, 2, 3, 2);
    check("t2_done_early", 32'(io_done), 32'd0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    check("t2_err", 32'(io_errCount), 32'd1);
    check("t2_fe_a", 32'(io_firstErr_a), 32'd3);
    check("t2_fe_b", 32'(io_firstErr_b), 32'd1);
    check("t2_fe_out", 32'(io_firstErr_out), 32'd3);
    check("t2_done", 32'(io_done), 32'd1);
    check("t2_pass", 32'(io_pass), 32'd0);

    // 3: stop on error at the third triple.
    step(0, 1, 8, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 3, 3, 3);
    step(0, 0, 0, 0, 1, 1, 2, 0);
    step(0, 0, 0, 0, 1, 2, 2, 0);
    check("t3_done", 32'(io_done), 32'd1);
    check("t3_count", 32'(io_sampleCount), 32'd3);
    check("t3_err", 32'(io_errCount), 32'd1);
    step(0, 0, 0, 0, 1, 1, 1, 1);
    check("t3_ready_after", 32'(io_in_ready), 32'd0);
    check("t3_count_hold", 32'(io_sampleCount), 32'd3);

    // 4: idle valid ignored, toggling valid, mid-run start ignored.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1, 1, 0);
    check("t4_idle_count", 32'(io_sampleCount), 32'd0);
    step(0, 1, 6, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, (i == 3), 2, 0, (i % 2 == 0), i & 3, 3, i & 3);
    check("t4_count_mid", 32'(io_sampleCount), 32'd4);
    check("t4_busy_mid", 32'(io_busy), 32'd1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, (i % 2 == 0), 2, 1, 0);
    check("t4_count_end", 32'(io_sampleCount), 32'd6);
    check("t4_pass", 32'(io_pass), 32'd1);

    // 5: reset mid-run, then a zero-length run.
    step(0, 1, 10, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 1, 3, 0);
    check("t5_err_pre", 32'(io_errCount), 32'd5);
    step(1, 0, 0, 0, 1, 1, 3, 0);
    check("t5_count_rst", 32'(io_sampleCount), 32'd0);
    check("t5_busy_rst", 32'(io_busy), 32'd0);
    check("t5_fe_rst", 32'(io_firstErr_valid), 32'd0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("t5_done0", 32'(io_done), 32'd1);
    check("t5_pass0", 32'(io_pass), 32'd1);
    check("t5_count0", 32'(io_sampleCount), 32'd0);

    // Randomized runs against the model.
    for (int r = 0; r < 40; r++) begin
      num = int'($urandom_range(0, 20));
      stp = 1'($urandom_range(0, 1));
      step(0, 1, num, stp, 0, 0, 0, 0);
      for (int c = 0; c < 40; c++) begin
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
        o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : (a & b);
        step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0),
             int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), a, b, o);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
